// File: rtl/data_mem_stage.sv
// data_mem_stage: MIPS32 data-memory stage. Holds a word-organised data memory
// that supports byte, halfword and word loads and stores. Load data is extended
// combinationally. Misaligned or illegal accesses are suppressed, and the first
// one is kept in a sticky fault register.
module data_mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        misaligned,
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    output logic        fault_is_store,
    output logic [7:0]  fault_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic [1:0]        off;
    logic [31:0]       word;
    logic [31:0]       merged;
    logic              illegal;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              unused_hi;

    // Upper address bits are ignored, so the memory wraps modulo its size.
    assign widx      = Address[ADDR_W+1:2];
    assign off       = Address[1:0];
    assign word      = mem[widx];
    assign unused_hi = ^Address[31:ADDR_W+2];

    // Check the access size against the byte offset; size 11 is never legal.
    always_comb begin
        illegal = 1'b0;
        case (mem_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = off[0];
            2'b10:   illegal = (off != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    assign misaligned = (memread | memwrite) & illegal;

    // Select the addressed lane and extend it. The output is forced to zero
    // when there is no legal load.
    always_comb begin
        ReadData = 32'h0;
        rd_byte  = word[{off, 3'b000} +: 8];
        rd_half  = word[{off[1], 4'b0000} +: 16];
        if (memread && !misaligned) begin
            case (mem_size)
                2'b00:   ReadData = {{24{rd_byte[7] & ~mem_unsigned}}, rd_byte};
                2'b01:   ReadData = {{16{rd_half[15] & ~mem_unsigned}}, rd_half};
                default: ReadData = word;
            endcase
        end
    end

    // Merge the store data into the current word; lanes that are not
    // addressed keep their contents.
    always_comb begin
        merged = word;
        case (mem_size)
            2'b00:   merged[{off, 3'b000} +: 8]     = WriteData[7:0];
            2'b01:   merged[{off[1], 4'b0000} +: 16] = WriteData[15:0];
            default: merged = WriteData;
        endcase
    end

    // Memory array: reset clears every word and drops a store presented in
    // the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (memwrite && !misaligned) begin
            mem[widx] <= merged;
        end
    end

    // Sticky fault capture: keep the first fault and count every fault,
    // saturating the count at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_valid    <= 1'b0;
            fault_addr     <= 32'h0;
            fault_is_store <= 1'b0;
            fault_count    <= 8'h0;
        end else if (misaligned) begin
            if (!fault_valid) begin
                fault_valid    <= 1'b1;
                fault_addr     <= Address;
                fault_is_store <= memwrite;
            end
            if (fault_count != 8'hFF) fault_count <= fault_count + 8'h1;
        end
    end

endmodule
